// File: rtl/full_adder_cell.sv
// ---------------------------------------------------------------------------
// full_adder_cell
//   1-bit full adder, the arithmetic leaf cell of the ripple chain.
//   Purely combinational.
//
// Ports:
//   a, b  : operand bits
//   cin   : carry into this bit
//   s     : sum bit,   a ^ b ^ cin
//   cout  : carry out, generate (a & b) or propagate (a ^ b) of cin
// ---------------------------------------------------------------------------
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  // Propagate term, shared by the sum and the carry.
  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/better_full_adder.sv
// ---------------------------------------------------------------------------
// better_full_adder
//   WIDTH-bit unsigned ripple-carry adder built from full_adder_cell leaves.
//   {cout, s} = a + b + cin, exact in WIDTH+1 bits. The sum and carry-out
//   are combinational. s_q and cout_q are copies captured on every rising
//   clock edge. There is no enable and no state machine.
//
// Parameters:
//   WIDTH  : operand width, 1..64 (default 1 = plain full adder)
//
// Ports:
//   clk    : clock, registers update on the rising edge
//   rst    : synchronous active-high reset, clears s_q and cout_q
//   a, b   : unsigned operands
//   cin    : carry into bit 0
//   s      : combinational sum (a + b + cin) mod 2^WIDTH
//   cout   : combinational carry out of the MSB
//   s_q    : s registered, one-cycle latency
//   cout_q : cout registered, one-cycle latency
// ---------------------------------------------------------------------------
module better_full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q
);

  // Carry chain: c[0] is the external carry-in, c[WIDTH] leaves the MSB.
  // The longest path runs cin -> c[1] -> ... -> c[WIDTH] through every cell.
  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[WIDTH];

  // Output register stage. Reset affects only these flops, the
  // combinational outputs keep tracking the inputs while rst is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s;
      cout_q <= cout;
    end
  end

endmodule

// File: tb/tb_better_full_adder.sv
module tb_better_full_adder;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUTs
  logic       a1, b1, cin1, s1, cout1, s_q1, cout_q1;
  logic [3:0] a4, b4, s4, s_q4;
  logic       cin4, cout4, cout_q4;
  logic [7:0] a8, b8, s8, s_q8;
  logic       cin8, cout8, cout_q8;

  better_full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1),
    .s(s1), .cout(cout1), .s_q(s_q1), .cout_q(cout_q1)
  );

  better_full_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4),
    .s(s4), .cout(cout4), .s_q(s_q4), .cout_q(cout_q4)
  );

  better_full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8),
    .s(s8), .cout(cout8), .s_q(s_q8), .cout_q(cout_q8)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Inputs change 2 ns after the rising edge; outputs are sampled either
  // 7 ns after the edge (mid-cycle) or 2 ns after the next edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive1(input logic a, input logic b, input logic c);
    a1 = a; b1 = b; cin1 = c;
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c);
    a4 = a; b4 = b; cin4 = c;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8 = a; b8 = b; cin8 = c;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic a;
    logic b;
    logic cin;
    logic exp_s;
    logic exp_cout;
  } vec1_t;

  vec1_t tbl[8];

  initial begin
    logic [8:0] ref_sum;
    logic [8:0] got;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Non-zero inputs during reset so a missing clear would show up.
    rst = 1'b1;
    drive1(1'b1, 1'b1, 1'b1);
    drive4(4'hA, 4'h7, 1'b1);
    drive8(8'hC3, 8'h5A, 1'b1);
    step();
    step();
    check("rst_s_q1",    s_q1,    0);
    check("rst_cout_q1", cout_q1, 0);
    check("rst_s_q4",    s_q4,    0);
    check("rst_cout_q4", cout_q4, 0);
    check("rst_s_q8",    s_q8,    0);
    check("rst_cout_q8", cout_q8, 0);
    // Combinational path still tracks inputs while reset is high.
    check("rst_comb_w1", {cout1, s1}, 2'b11);

    rst = 1'b0;

    // WIDTH=1 exhaustive sweep, each vector held 10 ns.
    for (int i = 0; i < 8; i++) begin
      drive1(tbl[i].a, tbl[i].b, tbl[i].cin);
      #5;
      check($sformatf("w1_s[%0d]", i),    s1,    tbl[i].exp_s);
      check($sformatf("w1_cout[%0d]", i), cout1, tbl[i].exp_cout);
      #5;
    end

    // WIDTH=1 registered latency: result appears only after the edge.
    step();
    drive1(1'b0, 1'b0, 1'b0);
    step();
    check("lat_pre_s_q", {cout_q1, s_q1}, 2'b00);
    drive1(1'b1, 1'b1, 1'b1);
    #5;
    check("lat_before_edge", {cout_q1, s_q1}, 2'b00);
    step();
    check("lat_s_q",    s_q1,    1'b1);
    check("lat_cout_q", cout_q1, 1'b1);

    // Mid-stream reset: registers clear, combinational sum unaffected.
    drive1(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    check("mrst_s_q",    s_q1,    1'b0);
    check("mrst_cout_q", cout_q1, 1'b0);
    check("mrst_s",      s1,      1'b1);
    rst = 1'b0;
    step();
    check("mrst_release_s_q", s_q1, 1'b1);

    // WIDTH=4 full carry ripple and no-carry all-ones sum.
    drive4(4'hF, 4'h0, 1'b1);
    #5;
    check("w4_ripple_s",    s4,    4'h0);
    check("w4_ripple_cout", cout4, 1'b1);
    step();
    check("w4_ripple_reg", {cout_q4, s_q4}, 5'h10);
    drive4(4'h7, 4'h8, 1'b0);
    #5;
    check("w4_prop_s",    s4,    4'hF);
    check("w4_prop_cout", cout4, 1'b0);
    step();

    // WIDTH=8 random against plain arithmetic; registered outputs checked
    // against the previous cycle's expected sum from the queue.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      if (i == 0) begin ra = 8'hFF; rb = 8'h00; rc = 1'b1; end
      if (i == 1) begin ra = 8'hFF; rb = 8'hFF; rc = 1'b1; end
      drive8(ra, rb, rc);
      drive4(ra[3:0], rb[7:4], rc);
      ref_sum = 9'(ra) + 9'(rb) + 9'(rc);
      #5;
      check("w8_comb", {cout8, s8}, ref_sum);
      check("w4_comb", {cout4, s4}, 5'(ra[3:0]) + 5'(rb[7:4]) + 5'(rc));
      exp_q.push_back(ref_sum);
      step();
      got = {cout_q8, s_q8};
      if (exp_q.size() == 0) begin
        check("w8_queue_empty", 1, 0);
      end else begin
        check("w8_reg", got, exp_q.pop_front());
      end
    end

    check("w8_queue_drained", exp_q.size(), 0);

    // ---------------------------------------------------------------- report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
